// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared constants and types for the adder tree scheduler.
//   NUM_OPS        - operands per tree operation (tree inputs in0..in7)
//   DEFAULT_DATA_W - default operand/sum width
//   sched_tag_t    - tag travelling alongside an operation {valid, id}
package adder_sched_pkg;

    localparam int unsigned NUM_OPS        = 8;
    localparam int unsigned DEFAULT_DATA_W = 8;
    // Widest requester index a tag can carry (up to 256 requesters).
    localparam int unsigned TAG_ID_W       = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } sched_tag_t;

endpackage

// File: rtl/adder_sched_rr_arb.sv
// adder_sched_rr_arb: combinational round-robin arbiter.
// Grants the lowest requester index >= i_rr_ptr (wrapping) whose request is high,
// only while i_en is high.
// Ports:
//   i_req_valid  in  NUM_REQ : request lines
//   i_rr_ptr     in  IDX_W   : highest-priority index this cycle
//   i_en         in  1       : grant enable
//   o_grant      out NUM_REQ : one-hot grant
//   o_grant_idx  out IDX_W   : encoded index of the grant (0 when none)
//   o_grant_vld  out 1       : a grant is issued
module adder_sched_rr_arb
    import adder_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_vld
);

    logic [IDX_W:0]   w_pos;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        w_pos       = '0;
        w_cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // Candidate index (rr_ptr + k) mod NUM_REQ, one spare bit for the wrap.
            w_pos = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
            if (w_pos >= (IDX_W+1)'(NUM_REQ)) begin
                w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
            end
            w_cand = w_pos[IDX_W-1:0];
            if (i_en && !o_grant_vld && i_req_valid[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
                o_grant_vld     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_tree_sched.sv
// adder_tree_sched: shares one 8-input pipelined adder tree between NUM_REQ requesters.
// Round-robin arbitration, a tag pipeline matched to the tree latency, and a FWFT result
// FIFO with valid/ready. Operations are issued only when a FIFO slot is guaranteed.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset (shared with the tree)
//   req_valid/req_ready   : per-requester request / one-hot grant (combinational)
//   req_data              : 8 operands per requester
//   tree_in / tree_sum    : operands to the tree / tree final_sum_reg
//   res_valid/res_ready   : result handshake; res_id = originating requester, res_data = sum
// Optional build macro ADDER_SCHED_STATS_EN adds stat_issued and stat_stall (16-bit,
// saturating) counters.
module adder_tree_sched
    import adder_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned PIPE_LAT   = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*NUM_OPS*DATA_W-1:0]  req_data,
    output logic [NUM_OPS*DATA_W-1:0]          tree_in,
    input  logic [DATA_W-1:0]                  tree_sum,
    output logic                               res_valid,
    output logic [$clog2(NUM_REQ)-1:0]         res_id,
    output logic [DATA_W-1:0]                  res_data,
    input  logic                               res_ready
`ifdef ADDER_SCHED_STATS_EN
    ,
    output logic [15:0]                        stat_issued,
    output logic [15:0]                        stat_stall
`endif
);

    localparam int unsigned IDX_W     = $clog2(NUM_REQ);
    localparam int unsigned SLICE_W   = NUM_OPS * DATA_W;
    // The tree registers its operands on the accept edge and updates final_sum_reg
    // PIPE_LAT edges later; the extra tag stage lines the tag up with a stable sum.
    localparam int unsigned TAG_DEPTH = PIPE_LAT + 1;
    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W     = $clog2(FIFO_DEPTH + TAG_DEPTH + 1);
    localparam int unsigned ENT_W     = IDX_W + DATA_W;

    sched_tag_t         r_tag [TAG_DEPTH];
    logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_rr_ptr;

    logic [OCC_W-1:0]   w_inflight;
    logic               w_credit_ok;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_grant_vld;
    logic               w_push;
    logic               w_pop;
    logic [ENT_W-1:0]   w_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
            w_inflight = w_inflight + OCC_W'(r_tag[i].valid);
        end
    end

    // Every accepted op holds one credit until it is popped, so the tree can never
    // deliver a sum into a full FIFO.
    assign w_credit_ok = (w_inflight + OCC_W'(r_count)) < OCC_W'(FIFO_DEPTH);

    adder_sched_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req_valid (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .i_en        (w_credit_ok && !rst),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld)
    );

    // A grant only goes to a valid requester, so grant and accept coincide.
    assign req_ready = w_grant;
    assign tree_in   = w_grant_vld ? req_data[32'(w_grant_idx) * SLICE_W +: SLICE_W] : '0;

    assign w_push    = r_tag[TAG_DEPTH-1].valid;
    assign res_valid = (r_count != '0);
    assign w_pop     = res_valid && res_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign res_id    = res_valid ? w_head[ENT_W-1:DATA_W] : '0;
    assign res_data  = res_valid ? w_head[DATA_W-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
                r_tag[i] <= '0;
            end
            r_rr_ptr <= '0;
        end else begin
            r_tag[0].valid <= w_grant_vld;
            r_tag[0].id    <= TAG_ID_W'(w_grant_idx);
            for (int unsigned i = 1; i < TAG_DEPTH; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (w_grant_vld) begin
                r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                 : w_grant_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_tag[TAG_DEPTH-1].id[IDX_W-1:0], tree_sum};
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

`ifdef ADDER_SCHED_STATS_EN
    logic [15:0] r_stat_issued;
    logic [15:0] r_stat_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_grant_vld && (r_stat_issued != 16'hFFFF)) begin
                r_stat_issued <= r_stat_issued + 16'd1;
            end
            if ((|req_valid) && !w_grant_vld && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_stall  = r_stat_stall;
`endif

endmodule
